axi_llc_resp_merger: RTL and testbench

Write-response merger for the LLC: the reverse end of the Ax burst cutter. The cutter splits one AXI AW burst into per-cache-line descriptors; this block collects the per-descriptor completions (one per descriptor, flagged `x_last` on the final one) and emits exactly one AXI B response per original burst. It sits between the LLC write-unit completion stream and the slave-port B channel.

---
 rtl/axi_llc_resp_merger.sv | 120 ++++++++++++
 tb/tb_axi_llc_resp_merger.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_llc_resp_merger.sv
// rtl/axi_llc_resp_merger.sv - merges per-line write completions into one AXI B response per burst
// Optional burst ID consistency check: define AXI_LLC_RESP_MERGER_ID_CHECK_EN.
typedef struct packed {
  logic       id;
  logic [1:0] resp;
  logic       user;
} axi_llc_resp_merger_b_t;

module axi_llc_resp_merger #(
  parameter type         b_chan_t = axi_llc_resp_merger_b_t,
  parameter type         id_t     = logic,
  parameter type         user_t   = logic,
  parameter int unsigned CntWidth = 9
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                frag_valid_i,
  output logic                frag_ready_o,
  input  id_t                 frag_id_i,
  input  user_t               frag_user_i,
  input  logic [1:0]          frag_resp_i,
  input  logic                frag_last_i,
  output logic                b_valid_o,
  input  logic                b_ready_i,
  output b_chan_t             b_o,
  output logic                busy_o,
`ifdef AXI_LLC_RESP_MERGER_ID_CHECK_EN
  output logic                id_err_o,
`endif
  output logic [CntWidth-1:0] frag_cnt_o
);

  typedef enum logic {IDLE, ACCUM} state_e;

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespExOkay = 2'b01;
  localparam logic [1:0] RespSlvErr = 2'b10;

  state_e              state_q;
  logic [1:0]          acc_resp_q;
  logic [CntWidth-1:0] acc_cnt_q;
  logic                b_valid_q;
  b_chan_t             b_q;
  logic                fire;
  logic [1:0]          merged;
  logic [1:0]          last_resp;

  // Errors dominate by severity; EXOKAY survives only if every fragment was exclusive.
  function automatic logic [1:0] merge_resp(input logic [1:0] a, input logic [1:0] b);
    if (a[1] || b[1]) return (a > b) ? a : b;
    return (a == RespExOkay && b == RespExOkay) ? RespExOkay : RespOkay;
  endfunction

  assign frag_ready_o = ~b_valid_q | b_ready_i;
  assign fire         = frag_valid_i & frag_ready_o;
  assign merged       = merge_resp(acc_resp_q, frag_resp_i);
  assign b_valid_o    = b_valid_q;
  assign b_o          = b_q;
  assign busy_o       = (state_q == ACCUM);
  assign frag_cnt_o   = acc_cnt_q;

`ifdef AXI_LLC_RESP_MERGER_ID_CHECK_EN
  id_t  first_id_q;
  logic burst_bad_q;
  logic id_err_q;
  logic id_mis;

  assign id_mis    = (state_q == ACCUM) && (frag_id_i != first_id_q);
  assign last_resp = (id_mis || burst_bad_q) ? RespSlvErr : merged;
  assign id_err_o  = id_err_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      first_id_q  <= '0;
      burst_bad_q <= 1'b0;
      id_err_q    <= 1'b0;
    end else if (fire) begin
      if (state_q == IDLE) first_id_q <= frag_id_i;
      if (id_mis) id_err_q <= 1'b1;
      burst_bad_q <= (state_q == ACCUM) && !frag_last_i && (burst_bad_q || id_mis);
    end
  end
`else
  assign last_resp = merged;
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      acc_resp_q <= RespOkay;
      acc_cnt_q  <= '0;
      b_valid_q  <= 1'b0;
      b_q        <= '0;
    end else begin
      if (b_ready_i) b_valid_q <= 1'b0;
      if (fire) begin
        if (frag_last_i) begin
          b_valid_q  <= 1'b1;
          b_q.id     <= frag_id_i;
          b_q.user   <= frag_user_i;
          b_q.resp   <= (state_q == ACCUM) ? last_resp : frag_resp_i;
          state_q    <= IDLE;
          acc_resp_q <= RespOkay;
          acc_cnt_q  <= '0;
        end else begin
          state_q <= ACCUM;
          if (state_q == IDLE) begin
            acc_resp_q <= frag_resp_i;
            acc_cnt_q  <= CntWidth'(1);
          end else begin
            acc_resp_q <= merged;
            // Saturate rather than wrap on absurdly long bursts.
            if (acc_cnt_q != '1) acc_cnt_q <= acc_cnt_q + CntWidth'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_axi_llc_resp_merger.sv
// tb/tb_axi_llc_resp_merger.sv - self-checking bench for axi_llc_resp_merger
module tb_axi_llc_resp_merger;

  typedef logic [3:0] id_t;
  typedef logic [1:0] user_t;
  typedef struct packed {
    id_t        id;
    logic [1:0] resp;
    user_t      user;
  } b_t;

  typedef struct {
    int              n;
    logic [3:0][1:0] r;
    id_t             id;
    logic [1:0]      exp;
  } vec_t;

  localparam logic [1:0] OK = 2'b00, EX = 2'b01, SE = 2'b10, DE = 2'b11;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic       frag_valid_i = 1'b0;
  logic       frag_ready_o;
  id_t        frag_id_i = '0;
  user_t      frag_user_i = '0;
  logic [1:0] frag_resp_i = '0;
  logic       frag_last_i = 1'b0;
  logic       b_valid_o;
  logic       b_ready_i = 1'b1;
  b_t         b_o;
  logic       busy_o;
  logic [8:0] frag_cnt_o;
`ifdef AXI_LLC_RESP_MERGER_ID_CHECK_EN
  logic       id_err_o;
`endif

  int n_vec = 0;
  int n_err = 0;
  b_t exp_q[$];
  vec_t vecs[8];

  always #5 clk_i = ~clk_i;

  axi_llc_resp_merger #(
    .b_chan_t (b_t),
    .id_t     (id_t),
    .user_t   (user_t),
    .CntWidth (9)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .frag_valid_i (frag_valid_i),
    .frag_ready_o (frag_ready_o),
    .frag_id_i    (frag_id_i),
    .frag_user_i  (frag_user_i),
    .frag_resp_i  (frag_resp_i),
    .frag_last_i  (frag_last_i),
    .b_valid_o    (b_valid_o),
    .b_ready_i    (b_ready_i),
    .b_o          (b_o),
    .busy_o       (busy_o),
`ifdef AXI_LLC_RESP_MERGER_ID_CHECK_EN
    .id_err_o     (id_err_o),
`endif
    .frag_cnt_o   (frag_cnt_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Handshakes complete on the rising edge; sample in the middle of the cycle.
  always @(negedge clk_i) begin
    if (rst_ni && b_valid_o && b_ready_i) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL b_unexpected: got id=%0d resp=%0d, expected no B", b_o.id, b_o.resp);
      end else begin
        b_t e;
        e = exp_q.pop_front();
        if (b_o !== e) begin
          n_err++;
          $display("FAIL b_payload: got id=%0d resp=%0d user=%0d, expected id=%0d resp=%0d user=%0d",
                   b_o.id, b_o.resp, b_o.user, e.id, e.resp, e.user);
        end
      end
    end
  end

  task automatic push(input id_t id, input logic [1:0] resp);
    b_t e;
    e.id = id; e.resp = resp; e.user = id[1:0];
    exp_q.push_back(e);
  endtask

  // Offers one fragment and returns 1 time unit after the edge where it was accepted.
  task automatic send(input id_t id, input logic [1:0] resp, input logic last);
    int   n;
    logic rdy;
    n = 0;
    frag_valid_i = 1'b1;
    frag_id_i = id;
    frag_user_i = id[1:0];
    frag_resp_i = resp;
    frag_last_i = last;
    forever begin
      @(negedge clk_i);
      rdy = frag_ready_o;
      @(posedge clk_i);
      #1;
      if (rdy) break;
      n++;
      if (n > 50) begin
        check("send_timeout", 32'd0, 32'd1);
        break;
      end
    end
    frag_valid_i = 1'b0;
  endtask

  initial begin
    b_t held;

    vecs[0] = '{n: 1, r: {OK, OK, OK, OK}, id: 4'd1, exp: OK};
    vecs[1] = '{n: 3, r: {OK, OK, SE, OK}, id: 4'd2, exp: SE};
    vecs[2] = '{n: 4, r: {EX, EX, EX, EX}, id: 4'd3, exp: EX};
    vecs[3] = '{n: 2, r: {OK, OK, OK, EX}, id: 4'd4, exp: OK};
    vecs[4] = '{n: 2, r: {OK, OK, DE, SE}, id: 4'd5, exp: DE};
    vecs[5] = '{n: 2, r: {OK, OK, OK, DE}, id: 4'd6, exp: DE};
    vecs[6] = '{n: 1, r: {OK, OK, OK, EX}, id: 4'd7, exp: EX};
    vecs[7] = '{n: 3, r: {OK, EX, SE, EX}, id: 4'd8, exp: SE};

    repeat (2) @(posedge clk_i);
    #1;
    check("rst_b_valid", 32'(b_valid_o), 32'd0);
    check("rst_b_o", 32'(b_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_cnt", 32'(frag_cnt_o), 32'd0);
    check("rst_frag_ready", 32'(frag_ready_o), 32'd1);
    rst_ni = 1'b1;

    // Single fragment: B exactly one cycle after acceptance.
    push(4'd3, OK);
    send(4'd3, OK, 1'b1);
    check("single_latency", 32'(b_valid_o), 32'd1);
    check("single_cnt", 32'(frag_cnt_o), 32'd0);
    check("single_busy", 32'(busy_o), 32'd0);

    // Three-fragment burst: counter/busy trace.
    send(4'd2, OK, 1'b0);
    check("b3_busy1", 32'(busy_o), 32'd1);
    check("b3_cnt1", 32'(frag_cnt_o), 32'd1);
    send(4'd2, SE, 1'b0);
    check("b3_busy2", 32'(busy_o), 32'd1);
    check("b3_cnt2", 32'(frag_cnt_o), 32'd2);
    push(4'd2, SE);
    send(4'd2, SE - 2'd2, 1'b1);
    check("b3_busy3", 32'(busy_o), 32'd0);
    check("b3_cnt3", 32'(frag_cnt_o), 32'd0);
    check("b3_valid", 32'(b_valid_o), 32'd1);

    // Merge table, fragments issued back to back.
    for (int v = 0; v < 8; v++) begin
      push(vecs[v].id, vecs[v].exp);
      for (int f = 0; f < vecs[v].n; f++)
        send(vecs[v].id, vecs[v].r[f], (f == vecs[v].n - 1));
    end

    // Back-to-back single-fragment bursts keep b_valid_o high every cycle.
    for (int k = 0; k < 3; k++) begin
      push(id_t'(10 + k), OK);
      send(id_t'(10 + k), OK, 1'b1);
      check("thru_valid", 32'(b_valid_o), 32'd1);
    end
    @(posedge clk_i);
    #1;

    // Back-pressure: pending B held stable, next last fragment stalls, then reload in place.
    b_ready_i = 1'b0;
    push(4'd7, DE);
    send(4'd7, DE, 1'b1);
    check("bp_valid", 32'(b_valid_o), 32'd1);
    held = b_o;
    push(4'd8, OK);
    frag_valid_i = 1'b1;
    frag_id_i = 4'd8;
    frag_user_i = 2'd0;
    frag_resp_i = OK;
    frag_last_i = 1'b1;
    repeat (5) begin
      @(negedge clk_i);
      check("bp_frag_ready", 32'(frag_ready_o), 32'd0);
      check("bp_b_stable", 32'(b_o), 32'(held));
    end
    @(posedge clk_i);
    #1;
    b_ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    frag_valid_i = 1'b0;
    check("bp_reload_valid", 32'(b_valid_o), 32'd1);
    check("bp_reload_id", 32'(b_o.id), 32'd8);
    @(posedge clk_i);
    #1;
    check("bp_drained", 32'(b_valid_o), 32'd0);

    // Reset in the middle of a burst discards it.
    send(4'd9, SE, 1'b0);
    send(4'd9, SE, 1'b0);
    check("mid_cnt", 32'(frag_cnt_o), 32'd2);
    rst_ni = 1'b0;
    @(posedge clk_i);
    #1;
    check("mid_rst_busy", 32'(busy_o), 32'd0);
    check("mid_rst_cnt", 32'(frag_cnt_o), 32'd0);
    check("mid_rst_valid", 32'(b_valid_o), 32'd0);
    check("mid_rst_b_o", 32'(b_o), 32'd0);
    rst_ni = 1'b1;
    push(4'd9, OK);
    send(4'd9, OK, 1'b1);

    // Burst whose fragments disagree on ID.
    send(4'd5, OK, 1'b0);
`ifdef AXI_LLC_RESP_MERGER_ID_CHECK_EN
    push(4'd6, SE);
`else
    push(4'd6, OK);
`endif
    send(4'd6, OK, 1'b1);
`ifdef AXI_LLC_RESP_MERGER_ID_CHECK_EN
    check("id_err_set", 32'(id_err_o), 32'd1);
    push(4'd1, EX);
    send(4'd1, EX, 1'b0);
    send(4'd1, EX, 1'b1);
    check("id_err_sticky", 32'(id_err_o), 32'd1);
`endif

    repeat (5) @(posedge clk_i);
    #1;
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
